// File: rtl/des_pkg.sv
// Shared DES types, permutation/S-box tables and the helpers that apply them.
// Used by the iterative controller (decrypt support: DES_DECRYPT_EN).
package des_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} des_state_t;

  localparam int SHIFT_T [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
    26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  localparam int SBOX_T [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Tables use DES numbering: entry 1 is the MSB of the input word.
  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0] k;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      k = 6'(i);
      y = {y[62:0], x[6'(64 - IP_T[k])]};
    end
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0] k;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      k = 6'(i);
      y = {y[62:0], x[6'(64 - FP_T[k])]};
    end
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    logic [5:0] k;
    y = '0;
    for (int i = 0; i < 56; i++) begin
      k = 6'(i);
      y = {y[54:0], x[6'(64 - PC1_T[k])]};
    end
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    logic [5:0] k;
    y = '0;
    for (int i = 0; i < 48; i++) begin
      k = 6'(i);
      y = {y[46:0], x[6'(56 - PC2_T[k])]};
    end
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y;
    logic [5:0] k;
    y = '0;
    for (int i = 0; i < 48; i++) begin
      k = 6'(i);
      y = {y[46:0], x[5'(32 - E_T[k])]};
    end
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    logic [4:0] k;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      k = 5'(i);
      y = {y[30:0], x[5'(32 - P_T[k])]};
    end
    return y;
  endfunction

  // Outer bits pick the row, inner four the column.
  function automatic logic [31:0] sbox_sub(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0] s;
    logic [5:0] a;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      s = 6'(x >> (42 - 6 * i));
      a = {s[5], s[0], s[4:1]};
      y = {y[27:0], 4'(SBOX_T[3'(i)][a])};
    end
    return y;
  endfunction

  function automatic logic [27:0] rot28(
    input logic [27:0] x,
    input logic [1:0]  n,
    input logic        right
  );
    logic [55:0] t;
    if (right) begin
      t = {x, x} >> n;
      return t[27:0];
    end
    t = {x, x} << n;
    return t[55:28];
  endfunction

endpackage

// File: rtl/des_iter_ctrl_if.sv
// Block/key/mode request and result handshake bundle for des_iter_ctrl.
interface des_iter_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        in_dec;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  modport master (
    output in_valid, in_data, in_key, in_dec, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_key, in_dec, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/des_round.sv
// Combinational DES f-function: expand, key mix, S-boxes, P.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);
  assign f_o = p_perm(sbox_sub(e_exp(r_i) ^ k_i));
endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative single-round DES engine, 16 rounds plus a final-permutation step.
// Define DES_DECRYPT_EN to honour in_dec and build the right-rotate schedule.
module des_iter_ctrl
  import des_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  des_iter_ctrl_if.slave bus
);

  des_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fin_q, fin_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic [63:0] out_q, out_d;

  logic        accept;
  logic [3:0]  rnd;
  logic [1:0]  sh;
  logic        dir;
  logic [27:0] c_n, d_n;
  logic [47:0] subkey;
  logic [31:0] f;
  logic [63:0] ip_in;
  logic [55:0] pc1_in;

  assign accept = (state_q == IDLE) && in_ready_q && bus.in_valid;
  // Round 16 is held as count 0, so rnd is the 0-based round index.
  assign rnd    = cnt_q - 4'd1;

`ifdef DES_DECRYPT_EN
  logic dec_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) dec_q <= 1'b0;
    else if (accept) dec_q <= bus.in_dec;

  // Decrypt walks the encrypt schedule backwards, starting unshifted.
  assign dir = dec_q;
  assign sh  = !dec_q ? 2'(SHIFT_T[rnd]) :
               (rnd == 4'd0) ? 2'd0 : 2'(SHIFT_T[4'd0 - rnd]);
`else
  logic unused_dec;
  assign unused_dec = bus.in_dec;
  assign dir = 1'b0;
  assign sh  = 2'(SHIFT_T[rnd]);
`endif

  assign c_n    = rot28(c_q, sh, dir);
  assign d_n    = rot28(d_q, sh, dir);
  assign subkey = pc2({c_n, d_n});
  assign ip_in  = ip(bus.in_data);
  assign pc1_in = pc1(bus.in_key);

  des_round u_round (
    .r_i (r_q),
    .k_i (subkey),
    .f_o (f)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fin_d       = fin_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    out_d       = out_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          {l_d, r_d} = ip_in;
          {c_d, d_d} = pc1_in;
          cnt_d      = 4'd1;
          fin_d      = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        if (fin_q) begin
          out_d       = fp({r_q, l_q});
          out_valid_d = 1'b1;
          fin_d       = 1'b0;
          state_d     = DONE;
        end else begin
          l_d = r_q;
          r_d = l_q ^ f;
          c_d = c_n;
          d_d = d_n;
          if (cnt_q == 4'd0) fin_d = 1'b1;
          else cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fin_q       <= fin_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Scoreboard bench for des_iter_ctrl: known DES vectors, latency,
// backpressure and mid-operation reset (decrypt vectors under DES_DECRYPT_EN).
module tb_des_iter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  des_iter_ctrl_if bus ();

  des_iter_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] k;
    logic [63:0] d;
    logic        m;
    logic [63:0] e;
  } vec_t;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] CZ = 64'h8CA64DE9C1B123A7;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  logic [63:0] sb [$];
  vec_t tv [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_out: got %h want none", bus.out_data);
      end else begin
        chk("out_data", bus.out_data, sb.pop_front());
      end
    end
  end

  task automatic send(input logic [63:0] k, input logic [63:0] d,
                      input logic m, input logic [63:0] e,
                      output int acc);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    bus.in_key   = k;
    bus.in_data  = d;
    bus.in_dec   = m;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      vecs++;
      errs++;
      $display("FAIL accept_timeout: got in_ready %b want 1", bus.in_ready);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    bus.in_key   = ~k;
    bus.in_dec   = ~m;
    @(negedge clk);
    acc = cyc;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    chk("ready_after_accept", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic wait_valid(input int acc, input string nm);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(cyc - acc), 64'd17);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run(input vec_t v);
    int acc;
    send(v.k, v.d, v.m, v.e, acc);
    wait_valid(acc, "latency");
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.in_dec    = 1'b0;
    bus.out_ready = 1'b1;

    tv.push_back('{K1, P1, 1'b0, C1});
    tv.push_back('{64'h0, 64'h0, 1'b0, CZ});
    tv.push_back('{64'h0101010101010101, 64'h0, 1'b0, CZ});
    tv.push_back('{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0});
`ifdef DES_DECRYPT_EN
    tv.push_back('{K1, C1, 1'b1, P1});
    tv.push_back('{64'h0, CZ, 1'b1, 64'h0});
`else
    tv.push_back('{64'h0, 64'h0, 1'b1, CZ});
`endif

    #1 rst = 1'b1;
    #20;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rel_in_ready_low", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    foreach (tv[i]) run(tv[i]);

    // Backpressure with a second request queued behind the held result.
    bus.out_ready = 1'b0;
    send(K1, P1, 1'b0, C1, acc);
    wait_valid(acc, "bp_latency");
    @(posedge clk);
    #1;
    bus.in_key   = 64'h0;
    bus.in_data  = 64'h0;
    bus.in_dec   = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_data", bus.out_data, C1);
      chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    sb.push_back(CZ);
    @(negedge clk);
    @(negedge clk);
    chk("bp_xfer_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_xfer_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("bp_second_busy", 64'(bus.busy), 64'd1);
    chk("bp_second_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_idle();

    // Reset while round 8 is in flight.
    send(K1, P1, 1'b0, C1, acc);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_data", bus.out_data, 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    run('{K1, P1, 1'b0, C1});

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
